pc_seq_ctrl: RTL and testbench
==============================

# pc_seq_ctrl

Fetch-side sequencer that owns the program counter register and decides, cycle by cycle, when the PC advances, holds, or is redirected. It sits between the hazard unit, the instruction-memory port and the combinational next-PC selector. It consumes the selector's target and the decode-stage Branch/Jump/Equal controls. It produces the fetch request, the fetched-PC tag, and the IF/ID flush. The PC is word-addressed (sequential step = +1).

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MAX_WAIT, 8, imem wait cycles tolerated before halt (legal range 2..255)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; one clock, synchronous, active-high
- Branch  input  2  00 none, 01 beq, 10 bne, 11 illegal
- Jump  input  2  00 none, 01 jr, 10 jal, 11 j
- Equal  input  1  comparator result for the branch
- next_pc_in  input  32  target from next-PC selector (already resolved)
- stall  input  1  downstream cannot accept an instruction
- imem_ready  input  1  imem completes the current request this cycle
- imem_req  output  1  fetch request; address = pc
- pc  output  32  current fetch PC, also selector in_pc
- fetch_valid  output  1  fetch_pc/instruction valid for IF/ID
- fetch_pc  output  32  PC of the instruction just completed
- flush  output  1  one-cycle pulse, kill IF/ID contents
- halted  output  1  sticky; imem timeout
- err_br  output  1  sticky; Branch==11 seen

## Operation

- taken = (Jump!=00) | (Branch==01 & Equal) | (Branch==10 & !Equal). Branch==11 is not taken and sets err_br.
- States: BOOT, FETCH, HOLD, HALT. imem_req = (state==FETCH).
- BOOT: entered on reset; unconditionally goes to FETCH next cycle.
- FETCH, in priority order:
  1. taken & !stall: pc<=next_pc_in, flush<=1, fetch_valid<=0, wait_cnt<=0; any in-flight completion is discarded; stay in FETCH.
  2. stall: go to HOLD, fetch_valid<=0, wait_cnt<=0, pc held.
  3. imem_ready: fetch_valid<=1, fetch_pc<=pc, pc<=pc+1 (wraps FFFF_FFFF to 0), wait_cnt<=0.
  4. Otherwise: wait_cnt++. When wait_cnt==MAX_WAIT-1, go to HALT and set halted<=1.
- HOLD: no request, fetch_valid<=0.
  - If !stall & taken: pc<=next_pc_in, flush<=1, go to FETCH.
  - If !stall & !taken: go to FETCH and re-fetch the same pc.
- HALT: absorbing until rst; pc frozen, no request.
- taken together with stall is ignored. Decode re-presents the redirect after the stall.
- wait_cnt is 8 bits and saturates.

## Timing

- Reset values: pc=RESET_PC, fetch_pc=0, fetch_valid=0, flush=0, halted=0, err_br=0, imem_req=0 (state BOOT), wait_cnt=0.
- All outputs are registered except imem_req, which is decoded from state.
- First request is in the cycle after rst deasserts.
- Zero-wait memory: imem_req & imem_ready in cycle N gives fetch_valid=1 with fetch_pc in N+1, and a new pc in N+1. Throughput is one fetch per cycle.
- flush is high exactly one cycle, the cycle after the redirect is accepted. fetch_valid=0 in that cycle.
- rst mid-fetch or mid-HOLD forces BOOT next cycle and drops the request. Sticky flags clear only on rst.

## Structure

- Shared package pc_pkg: pc_state_t enum {BOOT, FETCH, HOLD, HALT}, Branch encodings (BR_NONE/BR_BEQ/BR_BNE), Jump encodings (J_NONE/J_JR/J_JAL/J_J).
- One sub-module, pc_taken: combinational taken/illegal decode from Branch, Jump, Equal.
- The FSM, counter and registers live in pc_seq_ctrl.

## Test plan

- Reset release, imem_ready=1, no branches: pc goes 0,1,2,3; fetch_valid=1 from the second cycle with fetch_pc lagging by one; flush never asserts.
- imem_ready low 3 cycles with MAX_WAIT=8: pc holds at 5; one fetch_valid with fetch_pc=5 after ready; halted=0.
- beq, Equal=1, next_pc_in=0x40, no stall: pc=0x40 next cycle, one-cycle flush, fetch_valid=0 that cycle.
- bne with Equal=1: no redirect, pc+1. Branch=11: pc+1 and err_br=1, remaining set after Branch returns to 00.
- stall for 2 cycles while j is asserted with target 0x100, then stall drops with j held: state goes HOLD, then pc=0x100 with flush; no fetch_valid during the stall.
- imem_ready held 0 for 7 cycles with MAX_WAIT=8: HALT, halted=1, imem_req=0. A following rst pulse returns pc=RESET_PC and clears halted.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and control encodings for the fetch-side PC sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    HALT  = 2'b11
  } pc_state_t;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_ILL  = 2'b11;

  localparam logic [1:0] J_NONE  = 2'b00;
  localparam logic [1:0] J_JR    = 2'b01;
  localparam logic [1:0] J_JAL   = 2'b10;
  localparam logic [1:0] J_J     = 2'b11;

endpackage

// File: rtl/pc_taken.sv
// Redirect decode: any jump, or a branch whose condition holds.
// The reserved branch code never redirects; it is only flagged.
module pc_taken
  import pc_pkg::*;
(
  input  logic [1:0] Branch,
  input  logic [1:0] Jump,
  input  logic       Equal,
  output logic       taken,
  output logic       br_illegal
);

  // Combine jump and conditional-branch outcomes.
  always_comb begin
    taken      = 1'b0;
    br_illegal = 1'b0;
    if (Jump != J_NONE) taken = 1'b1;
    case (Branch)
      BR_BEQ:  if (Equal)  taken = 1'b1;
      BR_BNE:  if (!Equal) taken = 1'b1;
      BR_ILL:  br_illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: issues fetches, holds on stall, redirects on
// taken control flow and halts if instruction memory stops answering.
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// FETCH | request outstanding at pc
// HOLD  | downstream stalled, request withdrawn, pc held
// HALT  | imem timeout, frozen until reset
module pc_seq_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Branch,
  input  logic [1:0]  Jump,
  input  logic        Equal,
  input  logic [31:0] next_pc_in,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        flush,
  output logic        halted,
  output logic        err_br
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

  pc_state_t   state, state_nxt;
  logic [31:0] pc_nxt, fetch_pc_nxt;
  logic        fetch_valid_nxt, flush_nxt, halted_nxt, err_br_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt, wait_inc;
  logic        taken, br_illegal;

  pc_taken u_taken (
    .Branch     (Branch),
    .Jump       (Jump),
    .Equal      (Equal),
    .taken      (taken),
    .br_illegal (br_illegal)
  );

  assign imem_req = (state == FETCH);
  assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  // Next-state, next-PC and output-register decode.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    fetch_pc_nxt    = fetch_pc;
    fetch_valid_nxt = 1'b0;
    flush_nxt       = 1'b0;
    halted_nxt      = halted;
    err_br_nxt      = err_br | br_illegal;
    wait_cnt_nxt    = wait_cnt;
    case (state)
      BOOT: begin
        state_nxt    = FETCH;
        wait_cnt_nxt = 8'd0;
      end
      FETCH: begin
        if (taken && !stall) begin
          // Redirect wins over a completing fetch; that instruction is dropped.
          pc_nxt       = next_pc_in;
          flush_nxt    = 1'b1;
          wait_cnt_nxt = 8'd0;
        end else if (stall) begin
          state_nxt    = HOLD;
          wait_cnt_nxt = 8'd0;
        end else if (imem_ready) begin
          fetch_valid_nxt = 1'b1;
          fetch_pc_nxt    = pc;
          pc_nxt          = pc + 32'd1;
          wait_cnt_nxt    = 8'd0;
        end else begin
          wait_cnt_nxt = wait_inc;
          if (wait_inc == WAIT_LIMIT) begin
            state_nxt  = HALT;
            halted_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          state_nxt = FETCH;
          if (taken) begin
            pc_nxt    = next_pc_in;
            flush_nxt = 1'b1;
          end
        end
      end
      HALT: ;
      default: state_nxt = BOOT;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_pc    <= 32'd0;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      halted      <= 1'b0;
      err_br      <= 1'b0;
      wait_cnt    <= 8'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_pc    <= fetch_pc_nxt;
      fetch_valid <= fetch_valid_nxt;
      flush       <= flush_nxt;
      halted      <= halted_nxt;
      err_br      <= err_br_nxt;
      wait_cnt    <= wait_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a cycle-level behavioural model.
module tb_pc_seq_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          MW  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  Branch, Jump;
  logic        Equal, stall, imem_ready;
  logic [31:0] next_pc_in;
  logic        imem_req, fetch_valid, flush, halted, err_br;
  logic [31:0] pc, fetch_pc;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model
  logic [31:0] m_pc, m_fpc;
  logic        m_fv, m_flush, m_halted, m_err;
  bit          m_booting, m_holding, m_dead;
  int          m_misses;

  pc_seq_ctrl #(.RESET_PC(RPC), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .Branch(Branch), .Jump(Jump), .Equal(Equal),
    .next_pc_in(next_pc_in), .stall(stall), .imem_ready(imem_ready),
    .imem_req(imem_req), .pc(pc), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .flush(flush), .halted(halted), .err_br(err_br)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clock();
    bit tk;
    if (rst) begin
      m_pc = RPC; m_fpc = '0; m_fv = 0; m_flush = 0; m_halted = 0; m_err = 0;
      m_misses = 0; m_booting = 1; m_holding = 0; m_dead = 0;
      return;
    end
    tk = (Jump != 2'b00) || (Branch == 2'b01 && Equal) || (Branch == 2'b10 && !Equal);
    if (Branch == 2'b11) m_err = 1;
    m_fv = 0;
    m_flush = 0;
    if (m_booting) begin
      m_booting = 0;
      m_misses = 0;
    end else if (m_dead) begin
    end else if (m_holding) begin
      if (!stall) begin
        m_holding = 0;
        if (tk) begin m_pc = next_pc_in; m_flush = 1; end
      end
    end else if (tk && !stall) begin
      m_pc = next_pc_in; m_flush = 1; m_misses = 0;
    end else if (stall) begin
      m_holding = 1; m_misses = 0;
    end else if (imem_ready) begin
      m_fv = 1; m_fpc = m_pc; m_pc = m_pc + 1; m_misses = 0;
    end else begin
      m_misses++;
      if (m_misses >= MW - 1) begin m_dead = 1; m_halted = 1; end
    end
  endtask

  task automatic check_all();
    chk("imem_req",    32'(imem_req),    32'(!m_booting && !m_holding && !m_dead));
    chk("pc",          pc,               m_pc);
    chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    chk("fetch_pc",    fetch_pc,         m_fpc);
    chk("flush",       32'(flush),       32'(m_flush));
    chk("halted",      32'(halted),      32'(m_halted));
    chk("err_br",      32'(err_br),      32'(m_err));
  endtask

  task automatic step(input logic r, input logic [1:0] br, input logic [1:0] jp,
                      input logic eq, input logic [31:0] tgt,
                      input logic st, input logic rdy);
    rst = r; Branch = br; Jump = jp; Equal = eq; next_pc_in = tgt;
    stall = st; imem_ready = rdy;
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1; Branch = 0; Jump = 0; Equal = 0; next_pc_in = 0; stall = 0; imem_ready = 0;
    // reset
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("rst_pc", pc, RPC);
    chk("rst_req", 32'(imem_req), 32'd0);

    // sequential fetch, zero wait
    step(0, 0, 0, 0, 0, 0, 1);              // BOOT -> FETCH
    chk("boot_fv", 32'(fetch_valid), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("seq_pc", pc, 32'd3);
    chk("seq_fpc", fetch_pc, 32'd2);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("pre_wait_pc", pc, 32'd5);

    // three wait cycles at pc 5
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    chk("wait_pc", pc, 32'd5);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("wait_fv", 32'(fetch_valid), 32'd1);
    chk("wait_fpc", fetch_pc, 32'd5);
    chk("wait_halted", 32'(halted), 32'd0);

    // beq taken to 0x40
    step(0, 2'b01, 0, 1, 32'h40, 0, 1);
    chk("beq_pc", pc, 32'h40);
    chk("beq_flush", 32'(flush), 32'd1);
    chk("beq_fv", 32'(fetch_valid), 32'd0);
    step(0, 0, 0, 0, 32'h999, 0, 1);
    chk("beq_flush_done", 32'(flush), 32'd0);

    // bne with Equal=1 not taken, then illegal branch
    step(0, 2'b10, 0, 1, 32'h777, 0, 1);
    chk("bne_pc", pc, 32'h42);
    step(0, 2'b11, 0, 1, 32'h777, 0, 1);
    chk("ill_pc", pc, 32'h43);
    chk("ill_err", 32'(err_br), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("ill_sticky", 32'(err_br), 32'd1);

    // stall two cycles with j asserted, then release
    step(0, 0, 2'b11, 0, 32'h100, 1, 1);
    step(0, 0, 2'b11, 0, 32'h100, 1, 1);
    chk("hold_req", 32'(imem_req), 32'd0);
    step(0, 0, 2'b11, 0, 32'h100, 0, 1);
    chk("j_pc", pc, 32'h100);
    chk("j_flush", 32'(flush), 32'd1);

    // seven cycles without ready -> halt
    repeat (7) step(0, 0, 0, 0, 0, 0, 0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_req", 32'(imem_req), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("halt_pc", pc, 32'h100);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("rerst_pc", pc, RPC);
    chk("rerst_halted", 32'(halted), 32'd0);
    chk("rerst_err", 32'(err_br), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           2'($urandom_range(0, 9) == 0 ? $urandom_range(1, 3) : 0),
           2'($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0),
           1'($urandom_range(0, 1)),
           $urandom(),
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
